tge_pkt_sim_gen: RTL and testbench

Periodic test-packet generator for the 10GbE tutorial datapath. It sits directly downstream of the software-written pkt_sim_period and payload-length registers, which are already synchronous to user_clk. It sits directly upstream of the ten-GbE transmit interface. Every `period` cycles it emits one frame of 64-bit words carrying a sequence number and a word index, so the receiver can check for loss and ordering.

---
 rtl/tge_pkt_sim_pkg.sv | 18 +
 rtl/tge_pkt_sim_timer.sv | 27 ++
 rtl/tge_pkt_sim_gen.sv | 171 +++++++++++++++++
 tb/tb_tge_pkt_sim_gen.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/tge_pkt_sim_pkg.sv
// Shared types and defaults for the periodic test-packet generator.
// Optional build macro: TGE_PKT_SIM_DROP_CNT_EN (see tge_pkt_sim_gen).
package tge_pkt_sim_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int SEQ_W_DEF  = 32;
    localparam int LEN_W_DEF  = 16;

    // Shortest legal frame; a zero length is promoted to this.
    localparam int MIN_LEN = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        SEND = 2'd2
    } state_t;

endpackage

// File: rtl/tge_pkt_sim_timer.sv
// Period counter: fires a one-cycle tick every max(period,1) enabled cycles.
// A shrinking period that leaves the count past the new end wraps without a tick.
module tge_pkt_sim_timer (
    input  logic        user_clk,
    input  logic        user_rst_n,
    input  logic        i_enable,
    input  logic [31:0] i_period,
    output logic        o_tick
);

    logic [31:0] r_timer;
    logic [31:0] w_last;

    assign w_last = (i_period == 32'd0) ? 32'd0 : (i_period - 32'd1);
    assign o_tick = i_enable && (r_timer == w_last);

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_timer <= 32'd0;
        end else if (!i_enable || (r_timer >= w_last)) begin
            r_timer <= 32'd0;
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end

endmodule

// File: rtl/tge_pkt_sim_gen.sv
// Periodic 10GbE test-packet generator: frames of {seq, word_index} words.
// Define TGE_PKT_SIM_DROP_CNT_EN to add the drop_count output.
module tge_pkt_sim_gen
    import tge_pkt_sim_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEQ_W  = SEQ_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [31:0]       period,
    input  logic [31:0]       payload_len,
    input  logic              enable,
    input  logic              tx_afull,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_end_of_frame,
    output logic [31:0]       pkt_count,
    output logic              overrun
`ifdef TGE_PKT_SIM_DROP_CNT_EN
    ,
    output logic [31:0]       drop_count
`endif
);

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len < LEN_W'(MIN_LEN)) ? LEN_W'(MIN_LEN) : len;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_pending;
    logic               r_overrun;
    logic [SEQ_W-1:0]   r_seq;
    logic [31:0]        r_pkt_count;
    logic               r_tx_valid;
    logic [DATA_W-1:0]  r_tx_data;
    logic               r_tx_eof;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_idx;

    logic               w_tick;
    logic               w_start;
    logic               w_drop;
    logic               w_clr_pend;
    logic               w_advance;
    logic               w_done;
    logic [LEN_W-1:0]   w_len_start;
    logic [LEN_W-1:0]   w_idx_inc;
    logic               w_unused_len;

    assign w_unused_len = ^payload_len[31:LEN_W];

    tge_pkt_sim_timer u_timer (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .i_enable   (enable),
        .i_period   (period),
        .o_tick     (w_tick)
    );

    assign w_len_start = clamp_len(payload_len[LEN_W-1:0]);
    assign w_idx_inc   = r_idx + LEN_W'(1);
    assign w_advance   = (r_state == SEND) && !r_tx_eof;
    assign w_done      = (r_state == SEND) && r_tx_eof;

    // Disabling in ARM wins over a pending start so a stopped generator stays quiet.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_drop      = 1'b0;
        w_clr_pend  = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) w_state_nxt = ARM;
            end
            ARM: begin
                if (!enable) begin
                    w_clr_pend  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_pending) begin
                    w_clr_pend = 1'b1;
                    if (!tx_afull) begin
                        w_start     = 1'b1;
                        w_state_nxt = SEND;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            SEND: begin
                if (r_tx_eof) w_state_nxt = ARM;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_state     <= IDLE;
            r_pending   <= 1'b0;
            r_overrun   <= 1'b0;
            r_seq       <= '0;
            r_pkt_count <= 32'd0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= '0;
            r_tx_eof    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // A tick on the consuming cycle re-arms rather than being lost.
            if (w_tick) begin
                r_pending <= 1'b1;
            end else if (w_clr_pend) begin
                r_pending <= 1'b0;
            end
            if (w_tick && r_pending) r_overrun <= 1'b1;
            if (w_done) begin
                r_seq       <= r_seq + SEQ_W'(1);
                r_pkt_count <= r_pkt_count + 32'd1;
            end
            if (w_start) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= DATA_W'({32'(r_seq), 32'd0});
                r_tx_eof   <= (w_len_start == LEN_W'(MIN_LEN));
            end else if (w_advance) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= DATA_W'({32'(r_seq), 32'(w_idx_inc)});
                r_tx_eof   <= (w_idx_inc == (r_len - LEN_W'(1)));
            end else begin
                r_tx_valid <= 1'b0;
                r_tx_data  <= '0;
                r_tx_eof   <= 1'b0;
            end
        end
    end

    // Frame length and word index only matter inside SEND, so they carry no reset.
    always_ff @(posedge user_clk) begin
        if (w_start) begin
            r_len <= w_len_start;
            r_idx <= '0;
        end else if (w_advance) begin
            r_idx <= w_idx_inc;
        end
    end

`ifdef TGE_PKT_SIM_DROP_CNT_EN
    logic [31:0] r_drop_count;

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_drop_count <= 32'd0;
        end else if (w_drop) begin
            r_drop_count <= r_drop_count + 32'd1;
        end
    end

    assign drop_count = r_drop_count;
`else
    logic w_unused_drop;
    assign w_unused_drop = w_drop;
`endif

    assign tx_valid        = r_tx_valid;
    assign tx_data         = r_tx_data;
    assign tx_end_of_frame = r_tx_eof;
    assign pkt_count       = r_pkt_count;
    assign overrun         = r_overrun;

endmodule

// File: tb/tb_tge_pkt_sim_gen.sv
// Directed, table-driven bench for tge_pkt_sim_gen (drop_count checked when
// TGE_PKT_SIM_DROP_CNT_EN is defined).
module tb_tge_pkt_sim_gen;

    logic        user_clk = 1'b0;
    logic        user_rst_n = 1'b0;
    logic [31:0] period = 32'd0;
    logic [31:0] payload_len = 32'd0;
    logic        enable = 1'b0;
    logic        tx_afull = 1'b0;
    logic        tx_valid;
    logic [63:0] tx_data;
    logic        tx_end_of_frame;
    logic [31:0] pkt_count;
    logic        overrun;
`ifdef TGE_PKT_SIM_DROP_CNT_EN
    logic [31:0] drop_count;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    tge_pkt_sim_gen dut (
        .user_clk        (user_clk),
        .user_rst_n      (user_rst_n),
        .period          (period),
        .payload_len     (payload_len),
        .enable          (enable),
        .tx_afull        (tx_afull),
        .tx_valid        (tx_valid),
        .tx_data         (tx_data),
        .tx_end_of_frame (tx_end_of_frame),
        .pkt_count       (pkt_count),
        .overrun         (overrun)
`ifdef TGE_PKT_SIM_DROP_CNT_EN
        ,
        .drop_count      (drop_count)
`endif
    );

    always #5 user_clk = ~user_clk;

    typedef struct {
        int          scen;
        int          cyc;
        logic        v;
        logic [63:0] d;
        logic        e;
        logic [31:0] pc;
        logic        ov;
    } vec_t;

    vec_t tbl[$];
    int   sc_per[3] = '{10, 3, 0};
    int   sc_len[3] = '{4, 8, 0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge user_clk);
        #1;
        cyc++;
    endtask

    // Leaves the bench #1 after an edge with reset released; that cycle is cycle 0.
    task automatic apply_reset();
        user_rst_n = 1'b0;
        enable     = 1'b0;
        tx_afull   = 1'b0;
        repeat (2) @(posedge user_clk);
        #1;
        user_rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic add(input int s, input int c, input logic v, input logic [31:0] sq,
                       input logic [31:0] w, input logic e, input logic [31:0] pc, input logic ov);
        vec_t r;
        r.scen = s; r.cyc = c; r.v = v; r.e = e; r.pc = pc; r.ov = ov;
        r.d = v ? {sq, w} : 64'd0;
        tbl.push_back(r);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_valid;

        // period=10 len=4: tick in cycle 9, accepted in 10, words in 11..14
        add(0,  0, 0, 0, 0, 0, 0, 0);
        add(0, 10, 0, 0, 0, 0, 0, 0);
        add(0, 11, 1, 0, 0, 0, 0, 0);
        add(0, 12, 1, 0, 1, 0, 0, 0);
        add(0, 14, 1, 0, 3, 1, 0, 0);
        add(0, 15, 0, 0, 0, 0, 1, 0);
        add(0, 21, 1, 1, 0, 0, 1, 0);
        add(0, 24, 1, 1, 3, 1, 1, 0);
        add(0, 25, 0, 0, 0, 0, 2, 0);
        // period=3 len=8: back-to-back frames, ticks pile up into overrun
        add(1,  3, 0, 0, 0, 0, 0, 0);
        add(1,  4, 1, 0, 0, 0, 0, 0);
        add(1, 11, 1, 0, 7, 1, 0, 1);
        add(1, 12, 0, 0, 0, 0, 1, 1);
        add(1, 13, 1, 1, 0, 0, 1, 1);
        add(1, 22, 1, 2, 0, 0, 2, 1);
        add(1, 29, 1, 2, 7, 1, 2, 1);
        add(1, 30, 0, 0, 0, 0, 3, 1);
        // period=0 len=0: P=1, L=1, single-word frames on alternate cycles
        add(2,  1, 0, 0, 0, 0, 0, 0);
        add(2,  2, 1, 0, 0, 1, 0, 1);
        add(2,  3, 0, 0, 0, 0, 1, 1);
        add(2,  4, 1, 1, 0, 1, 1, 1);
        add(2,  5, 0, 0, 0, 0, 2, 1);
        add(2,  6, 1, 2, 0, 1, 2, 1);

        for (int s = 0; s < 3; s++) begin
            apply_reset();
            period      = sc_per[s];
            payload_len = sc_len[s];
            enable      = 1'b1;
            for (int i = 0; i < tbl.size(); i++) begin
                if (tbl[i].scen == s) begin
                    while (cyc < tbl[i].cyc) step();
                    chk($sformatf("s%0d_c%0d_valid", s, cyc), 64'(tx_valid), 64'(tbl[i].v));
                    chk($sformatf("s%0d_c%0d_data", s, cyc), tx_data, tbl[i].d);
                    chk($sformatf("s%0d_c%0d_eof", s, cyc), 64'(tx_end_of_frame), 64'(tbl[i].e));
                    chk($sformatf("s%0d_c%0d_pkt", s, cyc), 64'(pkt_count), 64'(tbl[i].pc));
                    chk($sformatf("s%0d_c%0d_ovr", s, cyc), 64'(overrun), 64'(tbl[i].ov));
                end
            end
        end

        // tx_afull held across ticks at 19, 39, 59: all three dropped
        apply_reset();
        period = 32'd20; payload_len = 32'd2; tx_afull = 1'b1; enable = 1'b1;
        seen_valid = 1'b0;
        while (cyc < 70) begin
            step();
            if (tx_valid) seen_valid = 1'b1;
        end
        chk("afull_no_valid", 64'(seen_valid), 64'd0);
        chk("afull_pkt", 64'(pkt_count), 64'd0);
        chk("afull_ovr", 64'(overrun), 64'd0);
`ifdef TGE_PKT_SIM_DROP_CNT_EN
        chk("afull_drop_count", 64'(drop_count), 64'd3);
`endif
        tx_afull = 1'b0;
        while (cyc < 80) step();
        chk("afull_c80_valid", 64'(tx_valid), 64'd0);
        step();
        chk("afull_c81_data", tx_data, {32'd0, 32'd0});
        chk("afull_c81_valid", 64'(tx_valid), 64'd1);
        step();
        chk("afull_c82_data", tx_data, {32'd0, 32'd1});
        chk("afull_c82_eof", 64'(tx_end_of_frame), 64'd1);

        // enable dropped while word 2 of 6 is on the bus
        apply_reset();
        period = 32'd5; payload_len = 32'd6; enable = 1'b1;
        while (cyc < 8) step();
        chk("en_c8_data", tx_data, {32'd0, 32'd2});
        enable = 1'b0;
        step();
        chk("en_c9_data", tx_data, {32'd0, 32'd3});
        while (cyc < 11) step();
        chk("en_c11_data", tx_data, {32'd0, 32'd5});
        chk("en_c11_eof", 64'(tx_end_of_frame), 64'd1);
        seen_valid = 1'b0;
        while (cyc < 30) begin
            step();
            if (tx_valid) seen_valid = 1'b1;
        end
        chk("en_no_more_valid", 64'(seen_valid), 64'd0);
        chk("en_pkt", 64'(pkt_count), 64'd1);

        // reset asserted during word 3 of the second frame
        apply_reset();
        period = 32'd5; payload_len = 32'd6; enable = 1'b1;
        while (cyc < 16) step();
        chk("rst_pre_data", tx_data, {32'd1, 32'd3});
        chk("rst_pre_pkt", 64'(pkt_count), 64'd1);
        user_rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(tx_valid), 64'd0);
        chk("rst_data", tx_data, 64'd0);
        chk("rst_pkt", 64'(pkt_count), 64'd0);
        chk("rst_eof", 64'(tx_end_of_frame), 64'd0);
        repeat (2) @(posedge user_clk);
        #1;
        user_rst_n = 1'b1;
        cyc = 0;
        while (cyc < 5) step();
        chk("rst_c5_valid", 64'(tx_valid), 64'd0);
        step();
        chk("rst_c6_data", tx_data, {32'd0, 32'd0});
        chk("rst_c6_valid", 64'(tx_valid), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
